// File: rtl/line_pkg.sv
// Shared types for the line rasteriser: coordinate/error widths and FSM states.
package line_pkg;

  localparam int unsigned COORD_W = 9;
  localparam int unsigned ERR_W   = COORD_W + 3;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [ERR_W-1:0] err_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } line_state_t;

endpackage

// File: rtl/line_draw_engine.sv
// Integer Bresenham line rasteriser: latches end-points on start and emits
// one pixel coordinate per valid/ready handshake, then pulses done.
module line_draw_engine
  import line_pkg::*;
(
  input  logic   HCLK,
  input  logic   HRESET,
  input  coord_t x1,
  input  coord_t y1,
  input  coord_t x2,
  input  coord_t y2,
  input  logic   start,
  output coord_t pix_x,
  output coord_t pix_y,
  output logic   pix_valid,
  input  logic   pix_ready,
  output logic   busy,
  output logic   done
);

  line_state_t state_q, state_d;
  coord_t      x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  coord_t      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  err_t        dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic        sx_pos_q, sx_pos_d, sy_pos_q, sy_pos_d;

  err_t        e2, err_n, ax1, ay1, ax2, ay2, abs_dx, abs_dy;

  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_pos_d = sx_pos_q;
    sy_pos_d = sy_pos_q;
    e2       = err_q <<< 1;
    err_n    = err_q;
    ax1      = err_t'(x1_q);
    ay1      = err_t'(y1_q);
    ax2      = err_t'(x2_q);
    ay2      = err_t'(y2_q);
    abs_dx   = (x1_q < x2_q) ? (ax2 - ax1) : (ax1 - ax2);
    abs_dy   = (y1_q < y2_q) ? (ay2 - ay1) : (ay1 - ay2);

    case (state_q)
      IDLE: begin
        if (start) begin
          x1_d    = x1;
          y1_d    = y1;
          x2_d    = x2;
          y2_d    = y2;
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d     = abs_dx;
        dy_d     = -abs_dy;
        sx_pos_d = (x1_q < x2_q);
        sy_pos_d = (y1_q < y2_q);
        err_d    = abs_dx - abs_dy;
        cur_x_d  = x1_q;
        cur_y_d  = y1_q;
        state_d  = DRAW;
      end
      DRAW: begin
        if (pix_ready) begin
          if (cur_x_q == x2_q && cur_y_q == y2_q) begin
            state_d = DONE;
          end else begin
            // Both tests use the pre-step e2, so a diagonal step may apply both.
            if (e2 >= dy_q) begin
              err_n   = err_n + dy_q;
              cur_x_d = sx_pos_q ? cur_x_q + coord_t'(1) : cur_x_q - coord_t'(1);
            end
            if (e2 <= dx_q) begin
              err_n   = err_n + dx_q;
              cur_y_d = sy_pos_q ? cur_y_q + coord_t'(1) : cur_y_q - coord_t'(1);
            end
            err_d = err_n;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_pos_q <= 1'b0;
      sy_pos_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_pos_q <= sx_pos_d;
      sy_pos_q <= sy_pos_d;
    end
  end

  assign pix_x     = cur_x_q;
  assign pix_y     = cur_y_q;
  assign pix_valid = (state_q == DRAW);
  assign busy      = (state_q == SETUP) || (state_q == DRAW);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: directed lines plus randomised
// lines and backpressure against an integer Bresenham reference model.
module tb_line_draw_engine;
  import line_pkg::*;

  logic   HCLK = 1'b0;
  logic   HRESET;
  coord_t x1, y1, x2, y2;
  logic   start, pix_ready;
  coord_t pix_x, pix_y;
  logic   pix_valid, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_q[$];
  int obs_q[$];
  int obs_cyc_q[$];
  int lat, done_cnt, stall_err, busy_err, timed_out, end_busy;

  always #5 HCLK = ~HCLK;

  line_draw_engine dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .x1        (x1),
    .y1        (y1),
    .x2        (x2),
    .y2        (y2),
    .start     (start),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done)
  );

  function automatic int pk(input int x, input int y);
    return x * 1024 + y;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: textbook integer Bresenham on plain ints.
  function automatic void build_expected(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, x, y, err, e2;
    dx  = iabs(bx - ax);
    dy  = -iabs(by - ay);
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    x   = ax;
    y   = ay;
    err = dx + dy;
    exp_q.delete();
    for (int i = 0; i < 2000; i++) begin
      exp_q.push_back(pk(x, y));
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  // Drives one line and records handshaken pixels plus protocol observations.
  // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
  task automatic draw(input int ax, input int ay, input int bx, input int by,
                      input int mode, input bit glitch);
    int cyc, vcnt, post, px, py;
    bit prev_stall, r;
    obs_q.delete();
    obs_cyc_q.delete();
    lat = -1; done_cnt = 0; stall_err = 0; busy_err = 0; timed_out = 0;
    cyc = 0; vcnt = 0; post = 0; prev_stall = 0; px = 0; py = 0;
    @(negedge HCLK);
    x1 = coord_t'(ax); y1 = coord_t'(ay); x2 = coord_t'(bx); y2 = coord_t'(by);
    start = 1'b1;
    pix_ready = 1'b0;
    forever begin
      @(negedge HCLK);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        x1 = coord_t'($urandom); y1 = coord_t'($urandom);
        x2 = coord_t'($urandom); y2 = coord_t'($urandom);
      end
      if (glitch && cyc == 4) start = 1'b1;
      if (pix_valid && lat < 0) lat = cyc;
      if (prev_stall && (!pix_valid || int'(pix_x) != px || int'(pix_y) != py)) stall_err++;
      if (done) begin
        done_cnt++;
        if (glitch) start = 1'b1;
      end
      if (busy !== (done_cnt == 0)) busy_err++;
      case (mode)
        0:       r = 1'b1;
        1:       r = ((vcnt % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pix_ready = r;
      if (pix_valid && r) begin
        obs_q.push_back(pk(int'(pix_x), int'(pix_y)));
        obs_cyc_q.push_back(cyc);
      end
      if (pix_valid) vcnt++;
      prev_stall = pix_valid && !r;
      px = int'(pix_x);
      py = int'(pix_y);
      if (done_cnt > 0) post++;
      if (post >= 3) break;
      if (cyc > 5000) begin timed_out = 1; break; end
    end
    pix_ready = 1'b0;
    start = 1'b0;
    end_busy = busy;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; start = 1'b0; pix_ready = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if ({pix_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/busy/done=%b required 000", {pix_valid, busy, done});
    end
    n_cmp++;
    if (pix_x !== '0 || pix_y !== '0) begin
      n_fail++;
      $display("FAIL reset_pix: got (%0d,%0d) required (0,0)", pix_x, pix_y);
    end
  endtask

  task automatic test_horizontal();
    draw(10, 5, 14, 5, 0, 0);
    n_cmp++;
    if (obs_q.size() != 5) begin n_fail++; $display("FAIL horiz_count: got %0d required 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] != pk(10 + i, 5)) begin
        n_fail++;
        $display("FAIL horiz_pix[%0d]: got (%0d,%0d) required (%0d,5)", i, obs_q[i] / 1024, obs_q[i] % 1024, 10 + i);
      end
    end
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL horiz_latency: got %0d required 2", lat); end
    n_cmp++;
    if (obs_cyc_q.size() == 5 && obs_cyc_q[4] - obs_cyc_q[0] != 4) begin
      n_fail++; $display("FAIL horiz_b2b: span %0d required 4", obs_cyc_q[4] - obs_cyc_q[0]);
    end
    n_cmp++;
    if (done_cnt != 1 || timed_out != 0) begin
      n_fail++; $display("FAIL horiz_done: got %0d pulses timeout=%0d required 1 pulse", done_cnt, timed_out);
    end
  endtask

  task automatic test_steep();
    int want[6];
    want = '{pk(0,0), pk(0,1), pk(1,2), pk(1,3), pk(2,4), pk(2,5)};
    draw(0, 0, 2, 5, 0, 0);
    n_cmp++;
    if (obs_q.size() != 6) begin n_fail++; $display("FAIL steep_count: got %0d required 6", obs_q.size()); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] != want[i]) begin
        n_fail++;
        $display("FAIL steep_pix[%0d]: got (%0d,%0d) required (%0d,%0d)", i, obs_q[i] / 1024, obs_q[i] % 1024, want[i] / 1024, want[i] % 1024);
      end
    end
    n_cmp++;
    if (busy_err != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL steep_busy_done: busy errors %0d done pulses %0d required 0 and 1", busy_err, done_cnt);
    end
  endtask

  task automatic test_reverse_diag();
    draw(300, 300, 297, 297, 2, 0);
    n_cmp++;
    if (obs_q.size() != 4) begin n_fail++; $display("FAIL revdiag_count: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] != pk(300 - i, 300 - i)) begin
        n_fail++;
        $display("FAIL revdiag_pix[%0d]: got (%0d,%0d) required (%0d,%0d)", i, obs_q[i] / 1024, obs_q[i] % 1024, 300 - i, 300 - i);
      end
    end
  endtask

  task automatic test_backpressure();
    int want[4];
    want = '{pk(0,0), pk(1,0), pk(2,1), pk(3,1)};
    draw(0, 0, 3, 1, 1, 0);
    n_cmp++;
    if (obs_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] != want[i]) begin
        n_fail++;
        $display("FAIL bp_pix[%0d]: got (%0d,%0d) required (%0d,%0d)", i, obs_q[i] / 1024, obs_q[i] % 1024, want[i] / 1024, want[i] % 1024);
      end
    end
    n_cmp++;
    if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles required 0", stall_err); end
    n_cmp++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_point();
    draw(511, 511, 511, 511, 0, 0);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] != pk(511, 511)) begin
      n_fail++; $display("FAIL point_pix: got %0d pixels first=%0d required 1 pixel (511,511)", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1);
    end
    n_cmp++;
    if (done_cnt != 1 || timed_out != 0) begin n_fail++; $display("FAIL point_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_start_busy();
    build_expected(40, 10, 48, 13);
    draw(40, 10, 48, 13, 2, 1);
    n_cmp++;
    if (obs_q != exp_q) begin
      n_fail++; $display("FAIL busy_start_pix: got %0d pixels required %0d matching model", obs_q.size(), exp_q.size());
    end
    n_cmp++;
    if (busy_err != 0 || end_busy !== 1'b0 || done_cnt != 1) begin
      n_fail++; $display("FAIL busy_start_ignored: busy errors %0d end busy %b done %0d required 0, 0, 1", busy_err, end_busy, done_cnt);
    end
  endtask

  task automatic test_reset_midline();
    int found, late_done;
    found = 0; late_done = 0;
    @(negedge HCLK);
    x1 = coord_t'(0); y1 = coord_t'(0); x2 = coord_t'(8); y2 = coord_t'(0);
    start = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      start = 1'b0;
      if (pix_valid && pix_x == coord_t'(2)) begin found = 1; break; end
    end
    n_cmp++;
    if (found == 0) begin n_fail++; $display("FAIL rst_mid_reach: third pixel not seen within 20 cycles"); end
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    pix_ready = 1'b0;
    n_cmp++;
    if ({pix_valid, busy, done} !== 3'b000 || pix_x !== '0) begin
      n_fail++; $display("FAIL rst_mid_state: got valid/busy/done=%b x=%0d required 000 x=0", {pix_valid, busy, done}, pix_x);
    end
    repeat (4) begin
      @(negedge HCLK);
      if (done) late_done++;
    end
    n_cmp++;
    if (late_done != 0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d done pulses required 0", late_done); end
    build_expected(20, 7, 17, 9);
    draw(20, 7, 17, 9, 0, 0);
    n_cmp++;
    if (obs_q != exp_q || done_cnt != 1) begin
      n_fail++; $display("FAIL rst_mid_redraw: got %0d pixels first=%0d required %0d first=%0d", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : -1, exp_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_random();
    int ax, ay, bx, by, span;
    for (int n = 0; n < 12; n++) begin
      ax = $urandom_range(0, 511);
      ay = $urandom_range(0, 511);
      span = (n % 2 == 0) ? 20 : 511;
      bx = ax + $urandom_range(0, 2 * span) - span;
      by = ay + $urandom_range(0, 2 * span) - span;
      bx = (bx < 0) ? 0 : (bx > 511) ? 511 : bx;
      by = (by < 0) ? 0 : (by > 511) ? 511 : by;
      build_expected(ax, ay, bx, by);
      draw(ax, ay, bx, by, 2, 0);
      n_cmp++;
      if (obs_q.size() != ((iabs(bx - ax) > iabs(by - ay)) ? iabs(bx - ax) : iabs(by - ay)) + 1) begin
        n_fail++; $display("FAIL rand_count[%0d]: (%0d,%0d)->(%0d,%0d) got %0d pixels", n, ax, ay, bx, by, obs_q.size());
      end
      n_cmp++;
      if (obs_q != exp_q) begin
        n_fail++; $display("FAIL rand_pix[%0d]: (%0d,%0d)->(%0d,%0d) got %0d pixels required %0d matching model", n, ax, ay, bx, by, obs_q.size(), exp_q.size());
      end
      n_cmp++;
      if (stall_err != 0 || busy_err != 0 || done_cnt != 1 || timed_out != 0) begin
        n_fail++; $display("FAIL rand_proto[%0d]: stall %0d busy %0d done %0d timeout %0d required 0 0 1 0", n, stall_err, busy_err, done_cnt, timed_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_reverse_diag();
    test_backpressure();
    test_point();
    test_start_busy();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
